// File: rtl/prim_fifo_ptr.sv
// Wrapping FIFO pointer: index bits that count 0..Depth-1 plus a wrap bit.
// The wrap bit toggles on each pass, so equal and unequal wrap bits tell empty from full.
module prim_fifo_ptr #(
   parameter int Depth = 4,
   localparam int IdxW = $clog2(Depth)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          incr_i,
   output logic [IdxW:0] ptr_o
);

   logic [IdxW:0] ptr_q;

   // Non-power-of-two depths need an explicit wrap at Depth-1, not a natural roll-over.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (clr_i) begin
         ptr_q <= '0;
      end else if (incr_i) begin
         if (ptr_q[IdxW-1:0] == IdxW'(Depth - 1)) begin
            ptr_q <= {~ptr_q[IdxW], {IdxW{1'b0}}};
         end else begin
            ptr_q <= ptr_q + (IdxW + 1)'(1);
         end
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/prim_fifo_sync.sv
// Single-clock FIFO with optional same-cycle pass-through when empty.
// Arbitrary depth (>= 2), occupancy count derived from wrap-bit pointers.
`ifndef PRIM_ASSERT_INIT
`define PRIM_ASSERT_INIT(name_, cond_) \
   if (!(cond_)) begin : name_ \
      $fatal(1, "prim_assert: static check failed"); \
   end
`endif

module prim_fifo_sync #(
   parameter int Width = 16,
   parameter int Depth = 4,
   parameter bit Pass  = 1'b1,
   localparam int DepthW = $clog2(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   input  logic [Width-1:0]  wdata_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [Width-1:0]  rdata_o,
   output logic              full_o,
   output logic [DepthW-1:0] depth_o
);

   localparam int IdxW = $clog2(Depth);

   `PRIM_ASSERT_INIT(gen_depth_min_check, Depth >= 2)

   logic [IdxW:0]    wptr, rptr;
   logic [IdxW-1:0]  widx, ridx;
   logic             wwrap, rwrap;
   logic             empty, full, pass_thru, push, pop;
   logic [Width-1:0] storage [Depth];

   assign widx  = wptr[IdxW-1:0];
   assign ridx  = rptr[IdxW-1:0];
   assign wwrap = wptr[IdxW];
   assign rwrap = rptr[IdxW];

   assign empty = (wptr == rptr);
   assign full  = (widx == ridx) && (wwrap != rwrap);

   // Pass-through consumes the write directly, so neither pointer nor storage moves.
   assign pass_thru = Pass && empty && wvalid_i && rready_i;
   assign push      = wvalid_i && !full && !pass_thru && !clr_i && !rst_i;
   assign pop       = rready_i && !empty && !clr_i && !rst_i;

   prim_fifo_ptr #(.Depth(Depth)) u_wptr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clr_i),
      .incr_i (push),
      .ptr_o  (wptr)
   );

   prim_fifo_ptr #(.Depth(Depth)) u_rptr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clr_i),
      .incr_i (pop),
      .ptr_o  (rptr)
   );

   always_ff @(posedge clk_i) begin
      if (push) begin
         storage[widx] <= wdata_i;
      end
   end

   always_comb begin
      depth_o = '0;
      if (full) begin
         depth_o = DepthW'(Depth);
      end else if (wwrap == rwrap) begin
         depth_o = DepthW'(widx) - DepthW'(ridx);
      end else begin
         depth_o = DepthW'(Depth) - DepthW'(ridx) + DepthW'(widx);
      end
   end

   always_comb begin
      rdata_o = '0;
      if (!empty) begin
         rdata_o = storage[ridx];
      end else if (Pass) begin
         rdata_o = wdata_i;
      end
   end

   assign full_o   = full;
   assign wready_o = !full;
   assign rvalid_o = !empty || (Pass && wvalid_i);

endmodule

// File: tb/tb_prim_fifo_sync.sv
// Scoreboard bench for prim_fifo_sync (Width=8, Depth=3, Pass=1).
module tb_prim_fifo_sync;

   localparam int W  = 8;
   localparam int D  = 3;
   localparam int DW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst, clr, wv, rr;
   logic [W-1:0]  wd;
   logic          wready, rvalid, full;
   logic [W-1:0]  rdata;
   logic [DW-1:0] depth;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [W-1:0]  exp_q[$];

   prim_fifo_sync #(.Width(W), .Depth(D), .Pass(1'b1)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .clr_i    (clr),
      .wvalid_i (wv),
      .wready_o (wready),
      .wdata_i  (wd),
      .rvalid_o (rvalid),
      .rready_i (rr),
      .rdata_o  (rdata),
      .full_o   (full),
      .depth_o  (depth)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, check outputs at the falling edge, then advance the model at the rising edge.
   task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r,
                                input logic c, input logic rs);
      bit           e, f;
      logic [W-1:0] exp_d;
      wv  = v;
      wd  = d;
      rr  = r;
      clr = c;
      rst = rs;
      @(negedge clk);
      e = (exp_q.size() == 0);
      f = (exp_q.size() == D);
      checkOutput("depth_o",  32'(depth),  32'(exp_q.size()));
      checkOutput("full_o",   32'(full),   32'(f));
      checkOutput("wready_o", 32'(wready), 32'(!f));
      checkOutput("rvalid_o", 32'(rvalid), 32'(!e || v));
      if (r && (!e || v)) begin
         exp_d = e ? d : exp_q[0];
         checkOutput("rdata_o", 32'(rdata), 32'(exp_d));
      end
      @(posedge clk);
      if (rs || c) begin
         exp_q.delete();
      end else if (!(e && v && r)) begin
         if (r && !e) void'(exp_q.pop_front());
         if (v && !f) exp_q.push_back(d);
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; wv = 1'b0; rr = 1'b0; wd = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // fill to full, then a dropped fourth write
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);

      // drain in order, then confirm empty
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // full with pop and push: push refused that cycle, accepted the next
      for (int i = 0; i < D; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < D + 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // streaming with one item held so both pointers wrap while depth stays at 1
      applyStimulus(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h81 + i), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // same-cycle pass-through on an empty FIFO
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // flush together with a push
      applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // reset mid-stream at depth 2
      applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hD3, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
